// File: rtl/penc_seq_arb_pkg.sv
// penc_seq_arb_pkg
//   Shared definitions for the sequential priority-encoder arbiter.
//   - PENC_MODE_MIN/MAX/RR/RSVD : raw MODE port encodings (also used by the bench)
//   - penc_mode_e               : internal selection mode after folding RSVD onto MIN
//   - decode_mode()             : MODE port value -> penc_mode_e
package penc_seq_arb_pkg;

  localparam logic [1:0] PENC_MODE_MIN  = 2'b00;
  localparam logic [1:0] PENC_MODE_MAX  = 2'b01;
  localparam logic [1:0] PENC_MODE_RR   = 2'b10;
  localparam logic [1:0] PENC_MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    SEL_MIN = 2'b00,
    SEL_MAX = 2'b01,
    SEL_RR  = 2'b10
  } penc_mode_e;

  // The reserved encoding behaves exactly like MIN.
  function automatic penc_mode_e decode_mode(input logic [1:0] m);
    case (m)
      PENC_MODE_MAX:                 return SEL_MAX;
      PENC_MODE_RR:                  return SEL_RR;
      PENC_MODE_MIN, PENC_MODE_RSVD: return SEL_MIN;
      default:                       return SEL_MIN;
    endcase
  endfunction

endpackage

// File: rtl/penc_rr_pick.sv
// penc_rr_pick
//   Combinational index picker for penc_seq_arb.
//   Ports:
//     x_i      [OPT-1:0]  request vector
//     mode_i   [1:0]      MODE encoding (MIN / MAX / RR, RSVD acts as MIN)
//     rr_ptr_i [LEN-1:0]  last round-robin winner
//     idx_o    [LEN-1:0]  selected index (0 when x_i is empty)
//     any_o               x_i has at least one bit set
//   RR is two lowest-first chains: requests strictly above rr_ptr first, and the
//   plain lowest-set chain as the wrap-around fallback (this also covers the
//   case where rr_ptr alone is requesting).
module penc_rr_pick
  import penc_seq_arb_pkg::*;
#(
  parameter  int LEN = 4,
  localparam int OPT = 2**LEN
) (
  input  logic [OPT-1:0] x_i,
  input  logic [1:0]     mode_i,
  input  logic [LEN-1:0] rr_ptr_i,
  output logic [LEN-1:0] idx_o,
  output logic           any_o
);

  logic [OPT-1:0] above;
  logic [OPT-1:0] masked;
  logic [LEN-1:0] lo_idx, hi_idx, rr_lo_idx, rr_idx;

  always_comb begin
    lo_idx    = '0;
    hi_idx    = '0;
    rr_lo_idx = '0;
    above     = '0;
    masked    = '0;
    rr_idx    = '0;

    // Lowest set: scan downward so the last hit is the smallest index.
    for (int i = OPT-1; i >= 0; i--)
      if (x_i[i]) lo_idx = LEN'(i);
    // Highest set: scan upward so the last hit is the largest index.
    for (int i = 0; i < OPT; i++)
      if (x_i[i]) hi_idx = LEN'(i);

    for (int i = 0; i < OPT; i++)
      above[i] = (LEN'(i) > rr_ptr_i);
    masked = x_i & above;

    for (int i = OPT-1; i >= 0; i--)
      if (masked[i]) rr_lo_idx = LEN'(i);
    rr_idx = (|masked) ? rr_lo_idx : lo_idx;

    case (decode_mode(mode_i))
      SEL_MAX: idx_o = hi_idx;
      SEL_RR:  idx_o = rr_idx;
      default: idx_o = lo_idx;
    endcase
  end

  assign any_o = |x_i;

endmodule

// File: rtl/penc_seq_arb.sv
// penc_seq_arb
//   Registered, valid/ready-handshaked priority encoder with runtime mode
//   select (lowest index, highest index, round-robin). One output stage,
//   latency 1, no skid buffer.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     X [OPT-1:0]         request vector
//     MODE [1:0]          00 MIN, 01 MAX, 10 RR, 11 MIN; sampled with X
//     in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//     Y [LEN-1:0]         registered selected index
//     Y_ANY               registered "captured X was non-empty"
//     out_valid/out_ready output handshake
//     Y_OH [OPT-1:0]      registered one-hot of Y (only when PENC_ONEHOT_EN defined)
//   Build macro: PENC_ONEHOT_EN adds the Y_OH port and its register.
module penc_seq_arb
  import penc_seq_arb_pkg::*;
#(
  parameter  int LEN = 4,
  localparam int OPT = 2**LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPT-1:0] X,
  input  logic [1:0]     MODE,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [LEN-1:0] Y,
  output logic           Y_ANY,
  output logic           out_valid,
  input  logic           out_ready
`ifdef PENC_ONEHOT_EN
  ,
  output logic [OPT-1:0] Y_OH
`endif
);

  typedef struct packed {
    logic           any;
    logic [LEN-1:0] idx;
  } res_t;

  logic [LEN-1:0] pick_idx;
  logic           pick_any;
  logic           cap;

  res_t           res_q, res_d;
  logic           vld_q, vld_d;
  logic [LEN-1:0] rr_ptr_q, rr_ptr_d;

  penc_rr_pick #(.LEN(LEN)) u_pick (
    .x_i      (X),
    .mode_i   (MODE),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign in_ready = !vld_q || out_ready;
  assign cap      = in_valid && in_ready;

  always_comb begin
    vld_d    = vld_q;
    res_d    = res_q;
    rr_ptr_d = rr_ptr_q;
    if (cap) begin
      // A capture also covers the drain-and-refill case: the new result
      // overwrites the one leaving this edge and valid stays high.
      vld_d     = 1'b1;
      res_d.any = pick_any;
      res_d.idx = pick_idx;
      // Only a real RR grant advances the pointer; empty vectors and
      // MIN/MAX transfers leave it where it was.
      if (pick_any && decode_mode(MODE) == SEL_RR) rr_ptr_d = pick_idx;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      res_q    <= '0;
      rr_ptr_q <= '1;
    end else begin
      vld_q    <= vld_d;
      res_q    <= res_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = vld_q;
  assign Y         = res_q.idx;
  assign Y_ANY     = res_q.any;

`ifdef PENC_ONEHOT_EN
  logic [OPT-1:0] oh_q, oh_d;

  always_comb begin
    oh_d = oh_q;
    if (cap) oh_d = pick_any ? (OPT'(1) << pick_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oh_q <= '0;
    else        oh_q <= oh_d;
  end

  assign Y_OH = oh_q;
`endif

endmodule

// File: tb/tb_penc_seq_arb.sv
// tb_penc_seq_arb
//   Directed checks with literal expectations, then randomized traffic checked
//   every cycle against a behavioural model (rotating search for RR).
module tb_penc_seq_arb;
  import penc_seq_arb_pkg::*;

  localparam int LEN = 4;
  localparam int OPT = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [OPT-1:0] X;
  logic [1:0]     MODE;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] Y;
  logic           Y_ANY;
  logic           out_valid;
  logic           out_ready;
`ifdef PENC_ONEHOT_EN
  logic [OPT-1:0] Y_OH;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  penc_seq_arb #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .MODE      (MODE),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .Y_ANY     (Y_ANY),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PENC_ONEHOT_EN
    ,
    .Y_OH      (Y_OH)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_valid = 0;
  int       m_y     = 0;
  bit       m_any   = 0;
  int       m_ptr   = OPT-1;

  function automatic int model_pick(input logic [OPT-1:0] x, input logic [1:0] mode, input int ptr);
    int r = 0;
    if (x == '0) return 0;
    if (mode == PENC_MODE_MAX) begin
      for (int i = 0; i < OPT; i++) if (x[i]) r = i;
      return r;
    end
    if (mode == PENC_MODE_RR) begin
      // Walk the ring starting just past ptr; ptr itself is the last candidate.
      for (int k = 1; k <= OPT; k++)
        if (x[(ptr + k) % OPT]) return (ptr + k) % OPT;
    end
    for (int i = OPT-1; i >= 0; i--) if (x[i]) r = i;
    return r;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_y = 0; m_any = 0; m_ptr = OPT-1;
    end else begin
      bit rdy;
      chk("out_valid", int'(out_valid), int'(m_valid));
      rdy = !m_valid || out_ready;
      chk("in_ready", int'(in_ready), int'(rdy));
      if (m_valid) begin
        chk("Y", int'(Y), m_y);
        chk("Y_ANY", int'(Y_ANY), int'(m_any));
`ifdef PENC_ONEHOT_EN
        chk("Y_OH", int'(Y_OH), m_any ? (1 << m_y) : 0);
`endif
      end
      if (in_valid && rdy) begin
        m_valid = 1;
        m_any   = (X != '0);
        m_y     = model_pick(X, MODE, m_ptr);
        if (m_any && MODE == PENC_MODE_RR) m_ptr = m_y;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [OPT-1:0] x, input logic [1:0] m, input bit ordy);
    in_valid  = v;
    X         = x;
    MODE      = m;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp [4] = '{0, 4, 15, 0};
    rst_n = 1'b0; in_valid = 0; X = '0; MODE = '0; out_ready = 1'b1;
    #12;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst Y", int'(Y), 0);
    chk("rst Y_ANY", int'(Y_ANY), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // MIN / MAX on 0x0A50
    step(1, 16'h0A50, PENC_MODE_MIN, 1);
    chk("min Y", int'(Y), 4);
    chk("min Y_ANY", int'(Y_ANY), 1);
    chk("min out_valid", int'(out_valid), 1);
    step(1, 16'h0A50, PENC_MODE_MAX, 1);
    chk("max Y", int'(Y), 11);
`ifdef PENC_ONEHOT_EN
    chk("max Y_OH", int'(Y_OH), 32'h0800);
`endif

    // RR fairness from the reset pointer
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h8011, PENC_MODE_RR, 1);
      chk("rr Y", int'(Y), rr_exp[i]);
    end

    // Empty vector: valid transfer, pointer untouched
    step(1, 16'h0000, PENC_MODE_RR, 1);
    chk("empty out_valid", int'(out_valid), 1);
    chk("empty Y", int'(Y), 0);
    chk("empty Y_ANY", int'(Y_ANY), 0);
`ifdef PENC_ONEHOT_EN
    chk("empty Y_OH", int'(Y_OH), 0);
`endif
    step(1, 16'h8011, PENC_MODE_RR, 1);
    chk("rr after empty", int'(Y), 4);
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h0001, PENC_MODE_RR, 1);
      chk("rr single", int'(Y), 0);
    end

    // Backpressure: held result stays, then refill with no bubble
    step(1, 16'h0A50, PENC_MODE_MIN, 1);
    chk("bp load", int'(Y), 4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; X = 16'h8011; MODE = PENC_MODE_MAX; out_ready = 0;
      #1;
      chk("bp in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("bp Y hold", int'(Y), 4);
      chk("bp valid hold", int'(out_valid), 1);
    end
    step(1, 16'h8011, PENC_MODE_MAX, 1);
    chk("bp refill Y", int'(Y), 15);
    chk("bp refill valid", int'(out_valid), 1);

    // Reset while a result is held
    step(0, 16'h0000, PENC_MODE_MIN, 1);
    step(1, 16'h0A50, PENC_MODE_MAX, 0);
    chk("pre-rst valid", int'(out_valid), 1);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", int'(out_valid), 0);
    chk("mid-rst Y", int'(Y), 0);
    chk("mid-rst Y_ANY", int'(Y_ANY), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 16'h8011, PENC_MODE_RR, 1);
    chk("rr after rst", int'(Y), 0);

    // Randomized traffic; the negedge model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      logic [OPT-1:0] x;
      int sel = $urandom_range(0, 3);
      case (sel)
        0: x = '0;
        1: x = OPT'(1) << $urandom_range(0, OPT-1);
        2: x = (OPT'(1) << $urandom_range(0, OPT-1)) | (OPT'(1) << $urandom_range(0, OPT-1));
        default: x = OPT'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), x, 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end

    step(0, '0, PENC_MODE_MIN, 1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
